// File: rtl/dcim_shift_acc.sv
// Bit-serial shift-accumulator behind the partial-sum adder: folds IN_BITS signed partial sums,
// MSB plane first, into one full-precision result presented on a valid/ready output register.
module dcim_shift_acc #(
    parameter int unsigned PSUM_W    = 24,
    parameter int unsigned IN_BITS   = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned SIGNED_IN = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             psum_valid,
    output logic                             psum_ready,
    input  logic [PSUM_W-1:0]                psum_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_W-1:0]                 out_data,
    output logic                             busy,
    output logic [$clog2(IN_BITS+1)-1:0]     plane_idx
);

    localparam int unsigned IDX_W = $clog2(IN_BITS + 1);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   psum_ext;
    logic [ACC_W-1:0]   acc_n;
    logic               accept;
    logic               last;
    logic               xfer;

    // A full output register stalls the input; no separate hold state is needed.
    assign psum_ready = !out_valid_q | out_ready;
    assign accept     = psum_valid & psum_ready & ~clear;
    assign last       = (idx_q == IDX_W'(IN_BITS - 1));
    assign xfer       = out_valid_q & out_ready;
    assign psum_ext   = {{(ACC_W - PSUM_W){psum_data[PSUM_W-1]}}, psum_data};

    // The first plane is the MSB plane; with signed activations it carries negative weight.
    always_comb begin
        if (idx_q == '0) begin
            acc_n = (SIGNED_IN != 0) ? (ACC_W'(0) - psum_ext) : psum_ext;
        end else begin
            acc_n = (acc_q << 1) + psum_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && (IN_BITS > 1)) state_d = StAccum;
            StAccum: if (accept && last)          state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (clear) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (clear) begin
            acc_d       = '0;
            idx_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (xfer) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                acc_d = acc_n;
                if (last) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_n;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy      = (state_q == StAccum);
        plane_idx = idx_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

endmodule

// File: tb/tb_dcim_shift_acc.sv
// Self-checking bench for dcim_shift_acc: a weighted-sum reference model checked every cycle,
// plus hand-computed literal results for each directed word.
module tb_dcim_shift_acc;

    localparam int PSUM_W  = 24;
    localparam int IN_BITS = 8;
    localparam int ACC_W   = 32;
    localparam int IDX_W   = $clog2(IN_BITS + 1);

    typedef logic [PSUM_W-1:0] word_t [IN_BITS];

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              clear      = 1'b0;
    logic              psum_valid = 1'b0;
    logic              out_ready  = 1'b1;
    logic [PSUM_W-1:0] psum_data  = '0;
    logic              psum_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              busy;
    logic [IDX_W-1:0]  plane_idx;

    always #5 clk = ~clk;

    dcim_shift_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_data  (psum_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .plane_idx  (plane_idx)
    );

    int               checks     = 0;
    int               errors     = 0;
    int               n_xfer     = 0;
    int               words_done = 0;
    bit               done       = 1'b0;
    bit               done_ack   = 1'b0;
    logic [ACC_W-1:0] lit_q [$];

    // Result as a weighted sum: plane k has weight 2^(IN_BITS-1-k), plane 0 negated.
    function automatic logic [ACC_W-1:0] word_value(input word_t p);
        longint s = 0;
        for (int k = 0; k < IN_BITS; k++) begin
            longint v = longint'(signed'(p[k]));
            longint w = longint'(1) << (IN_BITS - 1 - k);
            if (k == 0) s = s - v * w;
            else        s = s + v * w;
        end
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] model_result(input word_t pl, input logic [PSUM_W-1:0] lp);
        word_t t = pl;
        t[IN_BITS-1] = lp;
        return word_value(t);
    endfunction

    logic             m_valid = 1'b0;
    logic [ACC_W-1:0] m_data  = '0;
    int               m_cnt   = 0;
    word_t            m_pl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_cnt   <= 0;
        end else if (clear) begin
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (psum_valid && (!m_valid || out_ready)) begin
            m_pl[m_cnt] <= psum_data;
            if (m_cnt == IN_BITS - 1) begin
                m_valid <= 1'b1;
                m_data  <= model_result(m_pl, psum_data);
                m_cnt   <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_valid && out_ready) m_valid <= 1'b0;
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    function automatic void chk(input string name, input logic [ACC_W-1:0] act,
                                input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h, required 0x%08h", name, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        chk("out_valid", ACC_W'(out_valid), ACC_W'(m_valid));
        chk("psum_ready", ACC_W'(psum_ready), ACC_W'(!m_valid || out_ready));
        chk("plane_idx", ACC_W'(plane_idx), ACC_W'(m_cnt));
        chk("busy", ACC_W'(busy), ACC_W'(m_cnt != 0));
        if (m_valid) chk("out_data", out_data, m_data);
        if (!rst_n) chk("reset_out_data", out_data, '0);
        if (m_valid && out_ready && rst_n && !clear) begin
            n_xfer++;
            if (lit_q.size() > 0) chk("literal_result", out_data, lit_q.pop_front());
            else                  chk("unexpected_result", ACC_W'(1), ACC_W'(0));
        end
        if (done && !done_ack) begin
            chk("results_delivered", ACC_W'(n_xfer), ACC_W'(words_done));
            chk("literals_left", ACC_W'(lit_q.size()), '0);
            done_ack = 1'b1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the plane is taken.
    task automatic send_plane(input logic [PSUM_W-1:0] d);
        psum_valid = 1'b1;
        psum_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (psum_ready && !clear) begin
                #1;
                psum_valid = 1'b0;
                return;
            end
        end
        $display("FAIL send_plane: psum_ready never rose, got 0, required 1");
        $fatal(1, "stalled input");
    endtask

    task automatic send_word(input word_t p, input logic [ACC_W-1:0] lit, input int gap);
        lit_q.push_back(lit);
        for (int k = 0; k < IN_BITS; k++) begin
            send_plane(p[k]);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
        words_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    word_t w_x3    = '{24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd5, 24'd5};
    word_t w_m1    = '{24'd5, 24'd5, 24'd5, 24'd5, 24'd5, 24'd5, 24'd5, 24'd5};
    word_t w_range = '{24'h800000, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
    word_t w_ones  = '{24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1};

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(2);

        send_word(w_x3, 32'd15, 0);
        idle(3);
        send_word(w_m1, 32'hFFFF_FFFB, 1);
        idle(2);
        send_word(w_range, 32'h4000_0000, 0);
        idle(2);

        // Result held by downstream; the next word must wait, then both drain in order.
        out_ready = 1'b0;
        send_word(w_x3, 32'd15, 0);
        fork
            begin
                idle(6);
                out_ready = 1'b1;
            end
            send_word(w_range, 32'h4000_0000, 0);
        join
        send_word(w_m1, 32'hFFFF_FFFB, 0);
        idle(2);

        // Abort a partial word; the next word must not see the stale planes.
        for (int k = 0; k < 4; k++) send_plane(24'd1);
        clear      = 1'b1;
        psum_valid = 1'b1;
        psum_data  = 24'd1;
        idle(1);
        clear      = 1'b0;
        psum_valid = 1'b0;
        send_word(w_ones, 32'hFFFF_FFFF, 0);
        idle(2);

        // Asynchronous reset between edges, mid-word.
        for (int k = 0; k < 3; k++) send_plane(24'd7);
        #1 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        idle(1);
        send_word(w_x3, 32'd15, 2);
        idle(5);

        done = 1'b1;
        for (int i = 0; i < 20 && !done_ack; i++) @(negedge clk);
        if (!done_ack) begin
            $display("FAIL final_check: not reached, got 0, required 1");
            $fatal(1, "final check missing");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
